// File: rtl/ram_dma_bus_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_dma_pkg
//  Purpose  : Shared constants for the SSRAM <-> burst-bus DMA controller:
//             FSM state encoding, config register indices, control/status
//             bit positions and a start-command helper.
//  Revision : 1.0  initial release
// ============================================================================
package ram_dma_pkg;

    // FSM state encoding
    localparam int         STATE_W   = 3;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQUEST = 3'd1;
    localparam logic [2:0] S_INIT    = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_CLOSE   = 3'd5;

    // Config register indices
    localparam logic [2:0] REG_BUS_START  = 3'd0;
    localparam logic [2:0] REG_MEM_START  = 3'd1;
    localparam logic [2:0] REG_BLOCK_SIZE = 3'd2;
    localparam logic [2:0] REG_BURST_SIZE = 3'd3;
    localparam logic [2:0] REG_CONTROL    = 3'd4;
    localparam logic [2:0] REG_STATUS     = 3'd5;

    // Control register bits
    localparam int CTRL_START_READ  = 0;
    localparam int CTRL_START_WRITE = 1;

    // Status register bits
    localparam int STAT_BUSY  = 0;
    localparam int STAT_ERROR = 1;

    // A start command is legal only when exactly one direction bit is set
    function automatic logic start_bits_valid(input logic [1:0] bits);
        return bits[CTRL_START_READ] ^ bits[CTRL_START_WRITE];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_dma_bus_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_dma_bus_if
//  Purpose  : External burst-bus signal bundle between the DMA controller
//             (master) and the bus target/arbiter (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface ram_dma_bus_if;

    logic        bus_request;
    logic        bus_grant;
    logic        begin_transaction;
    logic        read_not_write;
    logic [7:0]  burst_size_out;
    logic [3:0]  byte_enables;
    logic [31:0] address_data_out;
    logic        data_valid_out;
    logic        end_transaction_out;
    logic [31:0] address_data_in;
    logic        data_valid_in;
    logic        busy_in;
    logic        end_transaction_in;
    logic        bus_error_in;

    modport master (
        output bus_request,
        input  bus_grant,
        output begin_transaction,
        output read_not_write,
        output burst_size_out,
        output byte_enables,
        output address_data_out,
        output data_valid_out,
        output end_transaction_out,
        input  address_data_in,
        input  data_valid_in,
        input  busy_in,
        input  end_transaction_in,
        input  bus_error_in
    );

    modport slave (
        input  bus_request,
        output bus_grant,
        input  begin_transaction,
        input  read_not_write,
        input  burst_size_out,
        input  byte_enables,
        input  address_data_out,
        input  data_valid_out,
        input  end_transaction_out,
        output address_data_in,
        output data_valid_in,
        output busy_in,
        output end_transaction_in,
        output bus_error_in
    );

endinterface
`default_nettype wire

// File: rtl/ram_dma_bus_controller_config_regs.sv
`default_nettype none
// ============================================================================
//  Module   : ram_dma_config_regs
//  Purpose  : CPU-visible DMA register file. Holds the transfer parameters,
//             flags control writes as start commands and provides a
//             combinational, zero-extended readback of the addressed register.
//  Revision : 1.0  initial release
// ============================================================================
module ram_dma_config_regs
    import ram_dma_pkg::*;
#(
    parameter int MEM_AW = 9,
    parameter int BLK_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        addr,
    input  logic [31:0]       data_in,
    input  logic              busy,
    input  logic              error,
    output logic [31:0]       data_out,
    output logic [31:0]       bus_start,
    output logic [MEM_AW-1:0] mem_start,
    output logic [BLK_W-1:0]  block_size,
    output logic [7:0]        burst_size,
    output logic              ctrl_write,
    output logic [1:0]        ctrl_bits
);

    logic [1:0] control;
    logic       accept;

    // Writes are only honoured while no transfer is in flight
    assign accept     = we && !busy;
    assign ctrl_write = accept && (addr == REG_CONTROL);
    assign ctrl_bits  = data_in[1:0];

    // Register file update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_start  <= '0;
            mem_start  <= '0;
            block_size <= '0;
            burst_size <= '0;
            control    <= '0;
        end else if (accept) begin
            case (addr)
                REG_BUS_START:  bus_start  <= data_in;
                REG_MEM_START:  mem_start  <= data_in[MEM_AW-1:0];
                REG_BLOCK_SIZE: block_size <= data_in[BLK_W-1:0];
                REG_BURST_SIZE: burst_size <= data_in[7:0];
                REG_CONTROL:    control    <= data_in[1:0];
                default:        ;
            endcase
        end
    end

    // Readback mux; unused indices read as zero
    always_comb begin
        data_out = '0;
        case (addr)
            REG_BUS_START:  data_out = bus_start;
            REG_MEM_START:  data_out = 32'(mem_start);
            REG_BLOCK_SIZE: data_out = 32'(block_size);
            REG_BURST_SIZE: data_out = 32'(burst_size);
            REG_CONTROL:    data_out = 32'(control);
            REG_STATUS: begin
                data_out[STAT_BUSY]  = busy;
                data_out[STAT_ERROR] = error;
            end
            default:        data_out = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ram_dma_bus_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ram_dma_bus_controller
//  Purpose  : DMA engine on SSRAM port B. Moves a block of words between the
//             SSRAM and the external burst bus, split into bursts of at most
//             burst_size+1 words, in either direction.
//  Revision : 1.0  initial release
// ============================================================================
module ram_dma_bus_controller
    import ram_dma_pkg::*;
#(
    parameter  int NR_OF_ENTRIES  = 512,
    parameter  int MAX_BLOCK_SIZE = 1023,
    localparam int MEM_AW         = $clog2(NR_OF_ENTRIES),
    localparam int BLK_W          = $clog2(MAX_BLOCK_SIZE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    // CPU configuration port
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [31:0]       cfg_data_in,
    output logic [31:0]       cfg_data_out,
    // External burst bus
    ram_dma_bus_if.master     bus,
    // SSRAM port B
    output logic [MEM_AW-1:0] mem_address,
    output logic              mem_write_enable,
    output logic [31:0]       mem_data_out,
    input  logic [31:0]       mem_data_in
);

    logic [STATE_W-1:0] state;
    logic               rnw;
    logic [31:0]        bus_addr;
    logic [MEM_AW-1:0]  mem_ptr;
    logic [BLK_W-1:0]   remaining;
    logic [8:0]         burst_len;
    logic [8:0]         words_done;
    logic               error;

    logic [31:0]        bus_start;
    logic [MEM_AW-1:0]  mem_start;
    logic [BLK_W-1:0]   block_size;
    logic [7:0]         burst_size;
    logic               ctrl_write;
    logic [1:0]         ctrl_bits;

    logic               busy;
    logic               start_ok;
    logic               start_conflict;
    logic [8:0]         burst_cap;
    logic [8:0]         next_len;
    logic               word_accept;
    logic               last_accept;
    logic               abort;

    ram_dma_config_regs #(
        .MEM_AW (MEM_AW),
        .BLK_W  (BLK_W)
    ) u_regs (
        .clk        (clk),
        .rst        (rst),
        .we         (cfg_we),
        .addr       (cfg_addr),
        .data_in    (cfg_data_in),
        .busy       (busy),
        .error      (error),
        .data_out   (cfg_data_out),
        .bus_start  (bus_start),
        .mem_start  (mem_start),
        .block_size (block_size),
        .burst_size (burst_size),
        .ctrl_write (ctrl_write),
        .ctrl_bits  (ctrl_bits)
    );

    // Command decode and per-burst length selection
    always_comb begin
        busy           = (state != S_IDLE);
        start_ok       = ctrl_write && start_bits_valid(ctrl_bits) && (block_size != '0);
        start_conflict = ctrl_write && (ctrl_bits == 2'b11);
        burst_cap      = {1'b0, burst_size} + 9'd1;
        // The tail burst is shorter when fewer words remain than a full burst
        if (BLK_W'(burst_cap) < remaining) begin
            next_len = burst_cap;
        end else begin
            next_len = 9'(remaining);
        end
        word_accept    = (state == S_WRITE) && !bus.busy_in;
        last_accept    = word_accept && ((words_done + 9'd1) == burst_len);
        abort          = busy && bus.bus_error_in;
    end

    // Bus and SSRAM outputs, all derived from the current state
    always_comb begin
        bus.bus_request         = busy;
        bus.begin_transaction   = (state == S_INIT);
        bus.read_not_write      = busy && rnw;
        bus.burst_size_out      = (state == S_INIT) ? 8'(burst_len - 9'd1) : 8'd0;
        bus.byte_enables        = ((state == S_INIT) || (state == S_READ) ||
                                   (state == S_WRITE) || (state == S_CLOSE)) ? 4'hF : 4'h0;
        bus.data_valid_out      = (state == S_WRITE);
        bus.end_transaction_out = (state == S_CLOSE) && !rnw;
        bus.address_data_out    = '0;
        if (state == S_INIT) begin
            bus.address_data_out = bus_addr;
        end else if (state == S_WRITE) begin
            bus.address_data_out = mem_data_in;
        end
        // Looking one word ahead on accept keeps the registered SSRAM read
        // output lined up with the next word to send, so bursts never bubble
        mem_address      = busy ? (mem_ptr + MEM_AW'(word_accept)) : '0;
        mem_write_enable = (state == S_READ) && bus.data_valid_in && !bus.bus_error_in;
        mem_data_out     = mem_write_enable ? bus.address_data_in : '0;
    end

    // Transfer FSM with its address, pointer and word counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rnw        <= 1'b0;
            bus_addr   <= '0;
            mem_ptr    <= '0;
            remaining  <= '0;
            burst_len  <= '0;
            words_done <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state     <= S_REQUEST;
                        rnw       <= ctrl_bits[CTRL_START_READ];
                        bus_addr  <= bus_start;
                        mem_ptr   <= mem_start;
                        remaining <= block_size;
                    end
                end
                S_REQUEST: begin
                    if (bus.bus_grant) begin
                        state      <= S_INIT;
                        burst_len  <= next_len;
                        words_done <= '0;
                    end
                end
                S_INIT: begin
                    bus_addr  <= bus_addr + 32'({burst_len, 2'b00});
                    remaining <= remaining - BLK_W'(burst_len);
                    state     <= rnw ? S_READ : S_WRITE;
                end
                S_READ: begin
                    if (bus.data_valid_in) begin
                        mem_ptr <= mem_ptr + 1'b1;
                    end
                    if (bus.end_transaction_in) begin
                        state <= S_CLOSE;
                    end
                end
                S_WRITE: begin
                    if (word_accept) begin
                        mem_ptr    <= mem_ptr + 1'b1;
                        words_done <= words_done + 9'd1;
                    end
                    if (last_accept) begin
                        state <= S_CLOSE;
                    end
                end
                S_CLOSE: begin
                    state <= (remaining != '0) ? S_REQUEST : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // A bus error overrides every other transition
            if (abort) begin
                state <= S_IDLE;
            end
        end
    end

    // Sticky error flag: set by bus error or conflicting start, cleared by a good start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error <= 1'b0;
        end else if (abort || start_conflict) begin
            error <= 1'b1;
        end else if (start_ok) begin
            error <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_dma_bus_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_dma_bus_controller
//  Purpose  : Self-checking bench for ram_dma_bus_controller: register
//             readback table, read/write/wrap transfers, bus error, illegal
//             start commands and reset during a write burst.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_dma_bus_controller;
    import ram_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_data_in;
    logic [31:0] cfg_data_out;
    logic [8:0]  mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;

    ram_dma_bus_if bus ();

    ram_dma_bus_controller dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_data_in      (cfg_data_in),
        .cfg_data_out     (cfg_data_out),
        .bus              (bus),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out),
        .mem_data_in      (mem_data_in)
    );

    always #5 clk = ~clk;

    // SSRAM model with registered read and a bench-side preload port
    logic [31:0] mem [512];
    logic        pre_we;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_write_enable) mem[mem_address] <= mem_data_out;
        mem_data_in <= mem[mem_address];
    end

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } cfg_vec_t;
    cfg_vec_t vecs [7];

    logic [31:0] begin_addr [$];
    logic [7:0]  begin_bs   [$];
    logic        begin_rnw  [$];
    logic [31:0] wr_words   [$];
    int          end_pulses;
    int          rd_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data_in = d;
        @(negedge clk);
        cfg_we = 1'b0; cfg_addr = REG_STATUS;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 9'(a); pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        cfg_addr = REG_STATUS;
        #1;
        check({tag, " bus_request"},  32'(bus.bus_request), 32'd0);
        check({tag, " begin"},        32'(bus.begin_transaction), 32'd0);
        check({tag, " rnw/burst/be"}, 32'({bus.read_not_write, bus.burst_size_out, bus.byte_enables}), 32'd0);
        check({tag, " addr_data"},    bus.address_data_out, 32'd0);
        check({tag, " dv/end out"},   32'({bus.data_valid_out, bus.end_transaction_out}), 32'd0);
        check({tag, " mem port"},     32'({mem_address, mem_write_enable}) | mem_data_out, 32'd0);
        check({tag, " status"},       cfg_data_out, 32'd0);
    endtask

    // Bus target: answers begin pulses, feeds read data, collects write data.
    // err_at: read word index that carries a bus error (-1 none);
    // stall_at: write word count at which busy is held for two cycles (-1 none).
    task automatic serve(input int err_at, input int stall_at);
        int  phase = 0;
        int  left = 0;
        int  busy_left = 0;
        bit  stalled = 0;
        bit  err_hit = 0;
        bit  done = 0;
        begin_addr.delete(); begin_bs.delete(); begin_rnw.delete(); wr_words.delete();
        end_pulses = 0; rd_count = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            bus.data_valid_in = 1'b0; bus.end_transaction_in = 1'b0;
            bus.bus_error_in = 1'b0; bus.busy_in = 1'b0; bus.address_data_in = '0;
            cfg_addr = REG_STATUS;
            #1;
            if (err_hit) begin
                check("bus_request after bus error", 32'(bus.bus_request), 32'd0);
                check("status after bus error", cfg_data_out, 32'h2);
                done = 1;
            end else if (bus.begin_transaction) begin
                begin_addr.push_back(bus.address_data_out);
                begin_bs.push_back(bus.burst_size_out);
                begin_rnw.push_back(bus.read_not_write);
                left  = int'(bus.burst_size_out) + 1;
                phase = bus.read_not_write ? 1 : 2;
            end else if (phase == 1 && left > 0) begin
                bus.data_valid_in      = 1'b1;
                bus.address_data_in    = 32'hA000_0000 + 32'(rd_count);
                bus.end_transaction_in = (left == 1);
                if (rd_count == err_at) begin
                    bus.bus_error_in = 1'b1;
                    err_hit = 1;
                end
                rd_count++;
                left--;
            end else if (phase == 2) begin
                if (stall_at >= 0 && !stalled && wr_words.size() == stall_at) begin
                    busy_left = 2;
                    stalled = 1;
                end
                if (busy_left > 0) begin
                    bus.busy_in = 1'b1;
                    busy_left--;
                end
                #1;
                if (bus.data_valid_out && !bus.busy_in) wr_words.push_back(bus.address_data_out);
                if (bus.end_transaction_out) begin
                    end_pulses++;
                    phase = 0;
                end
            end else if (cyc > 0 && cfg_data_out[STAT_BUSY] == 1'b0) begin
                done = 1;
            end
        end
        if (!done) begin
            total++;
            $display("FAIL serve timeout: transfer still busy after 400 cycles, expected idle");
        end
    endtask

    initial begin
        bit seen_write;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = REG_STATUS; cfg_data_in = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.bus_grant = 1'b0; bus.address_data_in = '0; bus.data_valid_in = 1'b0;
        bus.busy_in = 1'b0; bus.end_transaction_in = 1'b0; bus.bus_error_in = 1'b0;

        vecs[0] = '{REG_BUS_START,  32'h1234_5678, 32'h1234_5678};
        vecs[1] = '{REG_MEM_START,  32'hFFFF_FFFF, 32'h0000_01FF};
        vecs[2] = '{REG_BLOCK_SIZE, 32'hFFFF_FC05, 32'h0000_0005};
        vecs[3] = '{REG_BURST_SIZE, 32'h0000_0123, 32'h0000_0023};
        vecs[4] = '{REG_CONTROL,    32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{REG_STATUS,     32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6] = '{3'd6,           32'hFFFF_FFFF, 32'h0000_0000};

        repeat (2) @(negedge clk);
        check_outputs_zero("in reset");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("after reset");

        // Register write/readback table
        for (int i = 0; i < 7; i++) begin
            cfg_write(vecs[i].addr, vecs[i].wdata);
            cfg_addr = vecs[i].addr;
            #1;
            check($sformatf("cfg readback idx %0d", vecs[i].addr), cfg_data_out, vecs[i].exp);
        end

        bus.bus_grant = 1'b1;

        // Read: block 8, burst len 4, two bursts
        preload(8, 32'h5555_5555);
        cfg_write(REG_BUS_START, 32'h1000);
        cfg_write(REG_MEM_START, 32'd0);
        cfg_write(REG_BLOCK_SIZE, 32'd8);
        cfg_write(REG_BURST_SIZE, 32'd3);
        cfg_write(REG_CONTROL, 32'h1);
        serve(-1, -1);
        check("read burst count", 32'(begin_addr.size()), 32'd2);
        if (begin_addr.size() == 2) begin
            check("read burst0 addr", begin_addr[0], 32'h1000);
            check("read burst1 addr", begin_addr[1], 32'h1010);
            check("read burst sizes", 32'({begin_bs[0], begin_bs[1]}), 32'h0303);
            check("read rnw", 32'({begin_rnw[0], begin_rnw[1]}), 32'h3);
        end
        for (int i = 0; i < 8; i++) check($sformatf("read mem[%0d]", i), mem[i], 32'hA000_0000 + 32'(i));
        check("read mem[8] untouched", mem[8], 32'h5555_5555);

        // Write: block 5, one burst, target stalls two cycles mid-burst
        for (int i = 0; i < 5; i++) preload(64 + i, 32'hB000_0000 + 32'(i));
        cfg_write(REG_BUS_START, 32'h2000);
        cfg_write(REG_MEM_START, 32'd64);
        cfg_write(REG_BLOCK_SIZE, 32'd5);
        cfg_write(REG_BURST_SIZE, 32'd255);
        cfg_write(REG_CONTROL, 32'h2);
        serve(-1, 2);
        check("write word count", 32'(wr_words.size()), 32'd5);
        for (int i = 0; i < 5 && i < wr_words.size(); i++)
            check($sformatf("write word %0d", i), wr_words[i], 32'hB000_0000 + 32'(i));
        check("write end pulses", 32'(end_pulses), 32'd1);
        check("write burst count", 32'(begin_addr.size()), 32'd1);
        if (begin_addr.size() == 1) begin
            check("write burst addr", begin_addr[0], 32'h2000);
            check("write burst size/rnw", 32'({begin_bs[0], begin_rnw[0]}), 32'({8'd4, 1'b0}));
        end

        // Wrap: memStart 510, block 4 read
        preload(2, 32'h7777_7777);
        cfg_write(REG_MEM_START, 32'd510);
        cfg_write(REG_BLOCK_SIZE, 32'd4);
        cfg_write(REG_CONTROL, 32'h1);
        serve(-1, -1);
        check("wrap mem[510]", mem[510], 32'hA000_0000);
        check("wrap mem[511]", mem[511], 32'hA000_0001);
        check("wrap mem[0]",   mem[0],   32'hA000_0002);
        check("wrap mem[1]",   mem[1],   32'hA000_0003);
        check("wrap mem[2] untouched", mem[2], 32'h7777_7777);

        // Bus error on the second read word, then a restart clears the error
        cfg_write(REG_BUS_START, 32'h1000);
        cfg_write(REG_MEM_START, 32'd32);
        cfg_write(REG_BLOCK_SIZE, 32'd8);
        cfg_write(REG_BURST_SIZE, 32'd3);
        cfg_write(REG_CONTROL, 32'h1);
        serve(1, -1);
        cfg_write(REG_CONTROL, 32'h1);
        #1;
        check("status after restart", cfg_data_out, 32'h1);
        serve(-1, -1);
        for (int i = 0; i < 8; i++) check($sformatf("restart mem[%0d]", 32 + i), mem[32 + i], 32'hA000_0000 + 32'(i));

        // Both start bits set: error, no transfer
        cfg_write(REG_BLOCK_SIZE, 32'd4);
        cfg_write(REG_CONTROL, 32'h3);
        #1;
        check("conflict status", cfg_data_out, 32'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("conflict bus_request", 32'(bus.bus_request), 32'd0);
        end

        // Zero-length block: start is a no-op
        cfg_write(REG_BLOCK_SIZE, 32'd0);
        cfg_write(REG_CONTROL, 32'h1);
        #1;
        check("blocksize0 busy", 32'(cfg_data_out[STAT_BUSY]), 32'd0);
        @(negedge clk); #1;
        check("blocksize0 bus_request", 32'(bus.bus_request), 32'd0);

        // Config writes ignored while busy, then reset in the middle of a write burst
        bus.bus_grant = 1'b0;
        cfg_write(REG_BUS_START, 32'h3000);
        cfg_write(REG_MEM_START, 32'd64);
        cfg_write(REG_BLOCK_SIZE, 32'd5);
        cfg_write(REG_BURST_SIZE, 32'd255);
        cfg_write(REG_CONTROL, 32'h2);
        #1;
        check("request while ungranted", 32'(bus.bus_request), 32'd1);
        cfg_write(REG_BUS_START, 32'hDEAD_BEEF);
        cfg_addr = REG_BUS_START;
        #1;
        check("cfg write ignored while busy", cfg_data_out, 32'h3000);
        bus.bus_grant = 1'b1;
        seen_write = 0;
        for (int cyc = 0; cyc < 20 && !seen_write; cyc++) begin
            @(negedge clk); #1;
            if (bus.data_valid_out) seen_write = 1;
        end
        if (!seen_write) begin
            total++;
            $display("FAIL reset-mid-write setup: data_valid_out never rose, expected a write burst");
        end
        rst = 1'b1;
        check_outputs_zero("reset mid-write");
        cfg_addr = REG_BUS_START;
        #1;
        check("reset clears bus_start", cfg_data_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
